// File: rtl/encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder: format codes,
// opcodes, the canonical NOP, the write-FSM states and the field packer.
package encoder_pkg;

  typedef enum logic [2:0] {
    T_ILL0 = 3'b000,
    T_U    = 3'b001,
    T_J    = 3'b010,
    T_B    = 3'b011,
    T_I    = 3'b100,
    T_S    = 3'b101,
    T_R    = 3'b110,
    T_ILL7 = 3'b111
  } instr_type_e;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    W_IDLE  = 1'b0,
    W_WRITE = 1'b1
  } wr_state_e;

  // Immediate is in decoder convention; out-of-range bits are simply dropped.
  function automatic logic [31:0] encode(
    input instr_type_e t,
    input logic [6:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    logic [31:0] w;
    w = NOP;
    case (t)
      T_U: w = {imm[31:12], rd, op};
      T_J: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      T_B: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      T_I: w = {imm[11:0], rs1, f3, rd, op};
      T_S: w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      T_R: w = {f7, rs2, rs1, f3, rd, op};
      default: w = NOP;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO holding encoded words between the stage register and the
// memory write port. DEPTH must be a power of two.
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is legal only when the head leaves the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Pipelined RV32I encoder: field set -> stage register -> FIFO -> sequential
// memory writes. Optional immediate-range checking under ENCODE_CHECK_EN.
module instr_encoder
  import encoder_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_type,
  input  logic [6:0]                    in_op,
  input  logic [4:0]                    in_rd,
  input  logic [4:0]                    in_rs1,
  input  logic [4:0]                    in_rs2,
  input  logic [2:0]                    in_funct3,
  input  logic [6:0]                    in_funct7,
  input  logic [31:0]                   in_imm,
  input  logic                          addr_load,
  input  logic [31:0]                   addr_val,
  output logic                          mem_we,
  output logic [31:0]                   mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic                          mem_ack,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          enc_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            stage_valid;
  logic [31:0]     stage_word;
  logic            accept;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [31:0]     fifo_head;
  logic [CW-1:0]   fifo_count;
  logic [31:0]     addr;
  wr_state_e       state;

  assign pop      = (state == W_WRITE) & mem_ack;
  assign push     = stage_valid & (~fifo_full | pop);
  assign in_ready = ~stage_valid | ~fifo_full | pop;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid <= 1'b0;
      stage_word  <= '0;
    end else if (accept) begin
      stage_valid <= 1'b1;
      stage_word  <= encode(instr_type_e'(in_type), in_op, in_rd, in_rs1,
                            in_rs2, in_funct3, in_funct7, in_imm);
    end else if (push) begin
      stage_valid <= 1'b0;
    end
  end

  enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (stage_word),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Leaving WRITE looks at the push too, so a streaming source never stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= W_IDLE;
    end else begin
      case (state)
        W_IDLE:  if (!fifo_empty) state <= W_WRITE;
        W_WRITE: if (mem_ack && !(fifo_count > CW'(1) || push)) state <= W_IDLE;
        default: state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          addr <= RESET_ADDR;
    else if (addr_load) addr <= addr_val & ~32'h3;
    else if (pop)       addr <= addr + 32'd4;
  end

  assign mem_we    = (state == W_WRITE);
  assign mem_addr  = addr;
  assign mem_wdata = mem_we ? fifo_head : '0;
  assign count     = fifo_count;
  assign busy      = stage_valid | ~fifo_empty;

`ifdef ENCODE_CHECK_EN
  logic imm_bad;

  always_comb begin
    imm_bad = 1'b0;
    case (instr_type_e'(in_type))
      T_I, T_S: imm_bad = ~(&in_imm[31:11] | ~|in_imm[31:11]);
      T_B:      imm_bad = in_imm[0] | ~(&in_imm[31:12] | ~|in_imm[31:12]);
      T_J:      imm_bad = in_imm[0] | ~(&in_imm[31:20] | ~|in_imm[31:20]);
      T_U:      imm_bad = |in_imm[11:0];
      default:  imm_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) enc_err <= 1'b0;
    else       enc_err <= accept & imm_bad;
  end
`else
  assign enc_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed field sets with hand-encoded
// words; a negedge monitor checks every acknowledged write in order.
module tb_instr_encoder;
  import encoder_pkg::*;

  localparam logic [31:0] RST_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [6:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        addr_load;
  logic [31:0] addr_val;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [2:0]  count;
  logic        busy;
  logic        enc_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  t;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] exp_q [$];
  logic [31:0] mon_addr;

  instr_encoder #(.FIFO_DEPTH(4), .RESET_ADDR(RST_ADDR)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm), .addr_load(addr_load), .addr_val(addr_val),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .count(count), .busy(busy), .enc_err(enc_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] t, input logic [6:0] op,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] exp);
    vec_t v;
    v.t = t; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge (or timeout).
  task automatic send(input int idx, input int max_wait, output bit ok);
    ok = 1'b0;
    in_valid  = 1'b1;
    in_type   = vecs[idx].t;   in_op     = vecs[idx].op;
    in_rd     = vecs[idx].rd;  in_rs1    = vecs[idx].rs1;
    in_rs2    = vecs[idx].rs2; in_funct3 = vecs[idx].f3;
    in_funct7 = vecs[idx].f7;  in_imm    = vecs[idx].imm;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        exp_q.push_back(vecs[idx].exp);
      end else begin
        @(posedge clk);
      end
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic send_chk(input int idx);
    bit ok;
    send(idx, 20, ok);
    check("accept", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || busy || mem_we); i++) begin
      @(posedge clk); #1;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: reference address model follows the bench's own addr_load/ack drive.
  always @(negedge clk) begin
    logic [31:0] d;
    if (reset) begin
      exp_q.delete();
      mon_addr = RST_ADDR;
    end else if (mem_we && mem_ack) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write actual=%h expected=none", mem_wdata);
      end else begin
        d = exp_q.pop_front();
        check("wr_data", mem_wdata, d);
        check("wr_addr", mem_addr, mon_addr);
      end
      mon_addr = addr_load ? (addr_val & ~32'h3) : mon_addr + 32'd4;
    end else if (addr_load) begin
      mon_addr = addr_val & ~32'h3;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc;
    logic [31:0] exp_err;

    vecs[0] = mk(3'b110, OPC_OP,     5'd3, 5'd1, 5'd2,  3'd0, 7'd0,   32'h0000_0000, 32'h002081B3);
    vecs[1] = mk(3'b100, OPC_OP_IMM, 5'd5, 5'd0, 5'd31, 3'd0, 7'h7F,  32'hFFFF_FFFF, 32'hFFF00293);
    vecs[2] = mk(3'b011, OPC_BRANCH, 5'd9, 5'd1, 5'd2,  3'd0, 7'd0,   32'hFFFF_FFFC, 32'hFE208EE3);
    vecs[3] = mk(3'b000, OPC_OP,     5'd3, 5'd1, 5'd2,  3'd0, 7'd0,   32'h0000_0000, 32'h00000013);
    vecs[4] = mk(3'b001, OPC_LUI,    5'd1, 5'd0, 5'd0,  3'd0, 7'd0,   32'h1234_5000, 32'h123450B7);
    vecs[5] = mk(3'b010, OPC_JAL,    5'd1, 5'd0, 5'd0,  3'd0, 7'd0,   32'h0000_0008, 32'h008000EF);
    vecs[6] = mk(3'b101, OPC_STORE,  5'd0, 5'd1, 5'd2,  3'd2, 7'd0,   32'h0000_000C, 32'h0020A623);
    vecs[7] = mk(3'b100, OPC_OP_IMM, 5'd0, 5'd0, 5'd0,  3'd0, 7'd0,   32'h0000_0800, 32'h80000013);
    vecs[8] = mk(3'b111, OPC_OP,     5'd7, 5'd7, 5'd7,  3'd7, 7'h7F,  32'hDEAD_BEEF, 32'h00000013);
    vecs[9] = mk(3'b100, OPC_LOAD,   5'd4, 5'd2, 5'd0,  3'd2, 7'd0,   32'hFFFF_FFF8, 32'hFF812203);

`ifdef ENCODE_CHECK_EN
    exp_err = 32'd1;
`else
    exp_err = 32'd0;
`endif

    reset = 1'b1; in_valid = 1'b0; in_type = '0; in_op = '0; in_rd = '0;
    in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    addr_load = 1'b0; addr_val = '0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, RST_ADDR);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_enc_err", 32'(enc_err), 32'd0);

    // Latency: accept at edge k, FIFO at k+1, mem_we after k+2.
    mem_ack = 1'b1;
    send_chk(0);
    check("lat_we_k", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    check("lat_we_k1", 32'(mem_we), 32'd0);
    check("lat_count_k1", 32'(count), 32'd1);
    check("lat_busy_k1", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("lat_we_k2", 32'(mem_we), 32'd1);
    check("lat_addr_k2", mem_addr, 32'h0);
    check("lat_wdata_k2", mem_wdata, 32'h002081B3);

    // Back-to-back stream with ack held high.
    for (int i = 1; i <= 9; i++) if (i != 7) send_chk(i);
    check("enc_err_valid_imm", 32'(enc_err), 32'd0);
    drain();

    // Out-of-range I immediate.
    send_chk(7);
    check("enc_err_pulse", 32'(enc_err), exp_err);
    @(posedge clk); #1;
    check("enc_err_clear", 32'(enc_err), 32'd0);
    drain();

    // Full backpressure from a fresh reset.
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    mem_ack = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      send(i, 4, ok);
      acc += int'(ok);
    end
    check("full_accepted", 32'(acc), 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_count", 32'(count), 32'd4);
      check("full_we", 32'(mem_we), 32'd1);
      check("full_addr_hold", mem_addr, 32'h0);
      check("full_wdata_hold", mem_wdata, 32'h002081B3);
    end
    @(posedge clk); #1 mem_ack = 1'b1;
    drain();
    check("full_end_addr", mem_addr, 32'h14);

    // Address load with unaligned value.
    addr_load = 1'b1; addr_val = 32'h0000_1003;
    @(posedge clk); #1 addr_load = 1'b0;
    check("load_addr", mem_addr, 32'h1000);
    send_chk(4);
    send_chk(5);
    drain();

    // Address load coincident with an ack.
    mem_ack = 1'b0;
    send_chk(6);
    send_chk(8);
    for (int i = 0; i < 20 && !mem_we; i++) begin @(posedge clk); #1; end
    check("coinc_we", 32'(mem_we), 32'd1);
    check("coinc_old_addr", mem_addr, 32'h1008);
    mem_ack = 1'b1; addr_load = 1'b1; addr_val = 32'h0000_2001;
    @(posedge clk); #1 addr_load = 1'b0;
    check("coinc_new_addr", mem_addr, 32'h2000);
    drain();

    // Reset in the middle of WRITE with words queued.
    mem_ack = 1'b0;
    send_chk(4);
    send_chk(5);
    send_chk(6);
    for (int i = 0; i < 20 && !mem_we; i++) begin @(posedge clk); #1; end
    check("midrst_we_before", 32'(mem_we), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_addr", mem_addr, RST_ADDR);
    reset = 1'b0;
    mem_ack = 1'b1;
    send_chk(0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
